// File: rtl/ccip_if_pkg.sv
// rtl/ccip_if_pkg.sv - minimal CCI-P channel types used by the MMIO CSR responder
package ccip_if_pkg;

    typedef logic [27:0] t_ccip_c0_RspHdr;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_RspHdr hdr;
        logic [511:0]    data;
        logic            rspValid;
        logic            mmioRdValid;
        logic            mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

endpackage

// File: rtl/ccip_mmio_csr_pkg.sv
// rtl/ccip_mmio_csr_pkg.sv - register map, error bits and MMIO lengths for the CSR responder
package ccip_mmio_csr_pkg;
    import ccip_if_pkg::*;

    typedef t_ccip_c0_ReqMmioHdr t_mmio_req_hdr;

    localparam logic [15:0] WIN_DWORDS = 16'h0040;

    localparam logic [5:0] OFF_DFH      = 6'h00;
    localparam logic [5:0] OFF_AFU_ID_L = 6'h02;
    localparam logic [5:0] OFF_AFU_ID_H = 6'h04;
    localparam logic [5:0] OFF_SCRATCH  = 6'h10;
    localparam logic [5:0] OFF_ERROR    = 6'h18;
    localparam logic [5:0] OFF_WR_COUNT = 6'h1A;
    localparam logic [5:0] OFF_CYCLES   = 6'h1C;
    localparam logic [5:0] OFF_STATUS   = 6'h20;

    localparam int ERR_W = 3;

    typedef enum logic [1:0] {
        ERR_UNSUPPORTED   = 2'd0,
        ERR_MISALIGNED    = 2'd1,
        ERR_RD_WR_COLLIDE = 2'd2
    } t_err_bit;

    typedef enum logic [1:0] {
        MMIO_LEN_4B  = 2'b00,
        MMIO_LEN_8B  = 2'b01,
        MMIO_LEN_64B = 2'b10
    } t_mmio_len;

endpackage

// File: rtl/ccip_mmio_csr_responder_if.sv
// rtl/ccip_mmio_csr_responder_if.sv - bundle of the host MMIO channels seen by the CSR responder
interface ccip_mmio_csr_responder_if;
    import ccip_if_pkg::*;

    t_if_ccip_Rx    sRx;
    t_if_ccip_c2_Tx c2Tx;
    logic [63:0]    status_in;

    modport master (output sRx, output status_in, input c2Tx);
    modport slave  (input sRx, input status_in, output c2Tx);

endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// rtl/ccip_mmio_csr_responder.sv - CCI-P MMIO CSR window with a 2-stage in-order read pipeline
module ccip_mmio_csr_responder
    import ccip_if_pkg::*;
    import ccip_mmio_csr_pkg::*;
#(
    parameter logic [15:0]  MMIO_BASE   = 16'h0000,
    parameter logic [63:0]  DFH_VALUE   = 64'h1000_0000_0000_0000,
    parameter logic [127:0] AFU_ID      = 128'h0,
    parameter int           NUM_SCRATCH = 4
) (
    input  logic           pClk,
    input  logic           pck_cp2af_softReset,
    input  t_if_ccip_Rx    sRx,
    output t_if_ccip_c2_Tx c2Tx,
    input  logic [63:0]    status_in
);

    t_mmio_req_hdr w_hdr;
    logic [15:0]   w_off_full;
    logic [5:0]    w_off;
    logic [5:0]    w_reg_off;
    logic          w_in_win, w_rd, w_wr;
    logic          w_len_4b, w_len_8b, w_unsup, w_misalign, w_bad, w_wr_ok;
    logic [63:0]   w_wr_data, w_wr_mask, w_wr_masked;
    logic [ERR_W-1:0] w_err_set, w_err_clr;
    logic          w_unused;

    logic [63:0]      r_scratch [NUM_SCRATCH];
    logic [ERR_W-1:0] r_err;
    logic [31:0]      r_wr_count;
    logic [63:0]      r_cycles;

    logic        r_s1_valid;
    logic [8:0]  r_s1_tid;
    logic [5:0]  r_s1_off;
    logic        r_s1_4b;
    logic        r_s1_zero;
    logic [5:0]  w_s1_reg_off;
    logic [63:0] w_rd_reg, w_rd_data;

    logic        r_c2_valid;
    logic [8:0]  r_c2_tid;
    logic [63:0] r_c2_data;

    assign w_hdr      = t_mmio_req_hdr'(sRx.c0.hdr);
    assign w_off_full = w_hdr.address - MMIO_BASE;
    assign w_off      = w_off_full[5:0];
    assign w_reg_off  = {w_off[5:1], 1'b0};
    assign w_in_win   = (w_off_full < WIN_DWORDS) && !pck_cp2af_softReset;
    assign w_rd       = sRx.c0.mmioRdValid && w_in_win;
    assign w_wr       = sRx.c0.mmioWrValid && w_in_win;

    assign w_len_4b   = (w_hdr.length == MMIO_LEN_4B);
    assign w_len_8b   = (w_hdr.length == MMIO_LEN_8B);
    assign w_unsup    = !w_len_4b && !w_len_8b;
    assign w_misalign = w_len_8b && w_off[0];
    assign w_bad      = w_unsup || w_misalign;
    assign w_wr_ok    = w_wr && !w_bad;

    // A 4B write lands on one dword; replicating the data lets one mask serve both halves.
    assign w_wr_data   = w_len_4b ? {2{sRx.c0.data[31:0]}} : sRx.c0.data[63:0];
    assign w_wr_mask   = !w_len_4b ? '1 :
                         (w_off[0] ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF});
    assign w_wr_masked = w_wr_data & w_wr_mask;

    assign w_unused = ^{sRx.c0.data[511:64], sRx.c0.rspValid, sRx.c0TxAlmFull,
                        sRx.c1TxAlmFull, w_hdr.rsvd};

    always_comb begin
        w_err_set = '0;
        w_err_set[ERR_UNSUPPORTED]   = (w_rd || w_wr) && w_unsup;
        w_err_set[ERR_MISALIGNED]    = (w_rd || w_wr) && w_misalign;
        w_err_set[ERR_RD_WR_COLLIDE] = w_rd && w_wr;
        w_err_clr = '0;
        if (w_wr_ok && w_reg_off == OFF_ERROR)
            w_err_clr = w_wr_masked[ERR_W-1:0];
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                r_scratch[i] <= '0;
            r_err      <= '0;
            r_wr_count <= '0;
            r_cycles   <= '0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (w_wr_ok && w_reg_off == OFF_SCRATCH + 6'(2 * i))
                    r_scratch[i] <= (r_scratch[i] & ~w_wr_mask) | w_wr_masked;
            // Set is applied after clear so a same-cycle error event survives its W1C.
            r_err    <= (r_err & ~w_err_clr) | w_err_set;
            r_cycles <= r_cycles + 64'd1;
            if (w_wr)
                r_wr_count <= r_wr_count + 32'd1;
        end
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            r_s1_valid <= 1'b0;
            r_s1_tid   <= '0;
            r_s1_off   <= '0;
            r_s1_4b    <= 1'b0;
            r_s1_zero  <= 1'b0;
        end else begin
            r_s1_valid <= w_rd && !w_wr;
            r_s1_tid   <= w_hdr.tid;
            r_s1_off   <= w_off;
            r_s1_4b    <= w_len_4b;
            r_s1_zero  <= w_bad;
        end
    end

    assign w_s1_reg_off = {r_s1_off[5:1], 1'b0};

    always_comb begin
        w_rd_reg = '0;
        case (w_s1_reg_off)
            OFF_DFH:      w_rd_reg = DFH_VALUE;
            OFF_AFU_ID_L: w_rd_reg = AFU_ID[63:0];
            OFF_AFU_ID_H: w_rd_reg = AFU_ID[127:64];
            OFF_ERROR:    w_rd_reg = {{(64 - ERR_W){1'b0}}, r_err};
            OFF_WR_COUNT: w_rd_reg = {32'h0, r_wr_count};
            OFF_CYCLES:   w_rd_reg = r_cycles;
            OFF_STATUS:   w_rd_reg = status_in;
            default:      w_rd_reg = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (w_s1_reg_off == OFF_SCRATCH + 6'(2 * i))
                w_rd_reg = r_scratch[i];
    end

    assign w_rd_data = r_s1_zero ? 64'h0 :
                       r_s1_4b   ? {2{r_s1_off[0] ? w_rd_reg[63:32] : w_rd_reg[31:0]}} :
                       w_rd_reg;

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset || !r_s1_valid) begin
            r_c2_valid <= 1'b0;
            r_c2_tid   <= '0;
            r_c2_data  <= '0;
        end else begin
            r_c2_valid <= 1'b1;
            r_c2_tid   <= r_s1_tid;
            r_c2_data  <= w_rd_data;
        end
    end

    assign c2Tx.mmioRdValid = r_c2_valid;
    assign c2Tx.hdr.tid     = r_c2_tid;
    assign c2Tx.data        = r_c2_data;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// tb/tb_ccip_mmio_csr_responder.sv - directed self-checking bench for the MMIO CSR responder
module tb_ccip_mmio_csr_responder;
    import ccip_if_pkg::*;

    localparam logic [15:0]  BASE   = 16'h0100;
    localparam logic [63:0]  DFH    = 64'h1000_0000_0000_0000;
    localparam logic [127:0] AFU    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [1:0]   L4     = 2'b00;
    localparam logic [1:0]   L8     = 2'b01;
    localparam logic [1:0]   L64    = 2'b10;
    localparam logic [63:0]  AFU_LO = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0]  AFU_HI = 64'h0123_4567_89AB_CDEF;

    logic pClk = 1'b0;
    logic rst  = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt = 0;
    int   rst_cnt = 0;
    logic mon_en = 1'b0;

    logic [8:0]  exp_tid[$];
    logic [63:0] exp_data[$];
    int          exp_stamp[$];
    logic [8:0]  got_tid[$];
    logic [63:0] got_data[$];
    int          got_stamp[$];

    ccip_mmio_csr_responder_if bus();

    ccip_mmio_csr_responder #(
        .MMIO_BASE   (BASE),
        .DFH_VALUE   (DFH),
        .AFU_ID      (AFU),
        .NUM_SCRATCH (4)
    ) dut (
        .pClk                (pClk),
        .pck_cp2af_softReset (rst),
        .sRx                 (bus.sRx),
        .c2Tx                (bus.c2Tx),
        .status_in           (bus.status_in)
    );

    always #5 pClk = ~pClk;
    always @(posedge pClk) cnt <= cnt + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge pClk) begin
        if (mon_en) begin
            if (bus.c2Tx.mmioRdValid) begin
                got_tid.push_back(bus.c2Tx.hdr.tid);
                got_data.push_back(bus.c2Tx.data);
                got_stamp.push_back(cnt);
            end else begin
                check("idle_zero", {bus.c2Tx.hdr, bus.c2Tx.data}, '0);
            end
        end
    end

    function automatic logic [15:0] a(input logic [7:0] off);
        return BASE + 16'(off);
    endfunction

    task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
        t_ccip_c0_ReqMmioHdr h;
        h.address = addr;
        h.length  = len;
        h.rsvd    = 1'b0;
        h.tid     = tid;
        bus.sRx.c0.hdr         = h;
        bus.sRx.c0.data        = {448'h0, data};
        bus.sRx.c0.mmioRdValid = rd;
        bus.sRx.c0.mmioWrValid = wr;
        @(negedge pClk);
        bus.sRx.c0.mmioRdValid = 1'b0;
        bus.sRx.c0.mmioWrValid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [1:0] len,
                      input logic [8:0] tid, input logic [63:0] exp);
        exp_tid.push_back(tid);
        exp_data.push_back(exp);
        exp_stamp.push_back(cnt);
        req(1'b1, 1'b0, addr, len, tid, 64'h0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
        req(1'b0, 1'b1, addr, len, 9'h0, data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge pClk);
        rst_cnt = cnt;
        rst = 1'b0;
    endtask

    task automatic flush(input string grp);
        int n;
        repeat (4) @(negedge pClk);
        check({grp, "_rsp_count"}, 128'(got_tid.size()), 128'(exp_tid.size()));
        n = (got_tid.size() < exp_tid.size()) ? got_tid.size() : exp_tid.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_rsp%0d_tid", grp, i), 128'(got_tid[i]), 128'(exp_tid[i]));
            check($sformatf("%s_rsp%0d_data", grp, i), 128'(got_data[i]), 128'(exp_data[i]));
            check($sformatf("%s_rsp%0d_lat", grp, i), 128'(got_stamp[i] - exp_stamp[i]), 128'd2);
        end
        got_tid.delete(); got_data.delete(); got_stamp.delete();
        exp_tid.delete(); exp_data.delete(); exp_stamp.delete();
    endtask

    initial begin
        bus.sRx       = '0;
        bus.status_in = 64'h0;
        do_reset();
        mon_en = 1'b1;

        rd(a(8'h00), L8, 9'h1A5, DFH);
        wr(a(8'h10), L8, 64'h1122_3344_5566_7788);
        rd(a(8'h11), L4, 9'h002, 64'h1122_3344_1122_3344);
        rd(a(8'h1A), L8, 9'h003, 64'd1);
        rd(a(8'h02), L8, 9'h004, AFU_LO);
        rd(a(8'h05), L4, 9'h005, 64'h0123_4567_0123_4567);
        rd(a(8'h1C), L8, 9'h006, 64'(cnt + 1 - rst_cnt));
        bus.status_in = 64'hAAAA_AAAA_AAAA_AAAA;
        rd(a(8'h20), L8, 9'h007, 64'h5555_0000_1234_5678);
        bus.status_in = 64'h5555_0000_1234_5678;
        wr(a(8'h40), L8, 64'h99);
        wr(16'h00FF, L8, 64'h99);
        rd(a(8'h1A), L8, 9'h008, 64'd1);
        flush("basic");

        do_reset();
        wr(a(8'h12), L4, 64'hDEAD_BEEF);
        rd(a(8'h12), L8, 9'h010, 64'h0000_0000_DEAD_BEEF);
        rd(a(8'h1A), L8, 9'h011, 64'd1);
        wr(a(8'h13), L4, 64'hFFFF_FFFF_0BAD_F00D);
        rd(a(8'h12), L8, 9'h012, 64'h0BAD_F00D_DEAD_BEEF);
        wr(a(8'h00), L8, 64'h1234);
        rd(a(8'h00), L8, 9'h013, DFH);
        rd(a(8'h1A), L8, 9'h014, 64'd3);
        flush("dword");

        rd(a(8'h10), L64, 9'h020, 64'h0);
        rd(a(8'h11), L8, 9'h021, 64'h0);
        rd(a(8'h18), L8, 9'h022, 64'h3);
        wr(a(8'h18), L8, 64'h1);
        rd(a(8'h18), L8, 9'h023, 64'h2);
        req(1'b1, 1'b1, a(8'h14), L8, 9'h024, 64'h55);
        rd(a(8'h14), L8, 9'h025, 64'h55);
        rd(a(8'h18), L8, 9'h026, 64'h6);
        req(1'b1, 1'b1, a(8'h18), L8, 9'h027, 64'h4);
        rd(a(8'h18), L8, 9'h028, 64'h6);
        wr(a(8'h18), L8, 64'h7);
        rd(a(8'h18), L8, 9'h029, 64'h0);
        wr(a(8'h15), L8, 64'hFF);
        rd(a(8'h14), L8, 9'h02A, 64'h55);
        rd(a(8'h18), L8, 9'h02B, 64'h2);
        rd(a(8'h1A), L8, 9'h02C, 64'd8);
        flush("errors");

        rd(a(8'h00), L8, 9'h030, DFH);
        rd(a(8'h02), L8, 9'h031, AFU_LO);
        rd(a(8'h04), L8, 9'h032, AFU_HI);
        rd(a(8'h10), L8, 9'h033, 64'h0);
        flush("b2b");

        req(1'b1, 1'b0, a(8'h40), L8, 9'h040, 64'h0);
        req(1'b1, 1'b0, 16'h00FF, L8, 9'h041, 64'h0);
        req(1'b1, 1'b0, a(8'h00), L8, 9'h042, 64'h0);
        rst = 1'b1;
        req(1'b0, 1'b1, a(8'h10), L8, 9'h0, 64'hFFFF);
        rst_cnt = cnt;
        rst = 1'b0;
        flush("drop");

        rd(a(8'h10), L8, 9'h050, 64'h0);
        rd(a(8'h1A), L8, 9'h051, 64'h0);
        rd(a(8'h18), L8, 9'h052, 64'h0);
        rd(a(8'h1C), L8, 9'h053, 64'(cnt + 1 - rst_cnt));
        flush("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
